pixel_packet_framer: RTL
========================

PIXEL_PACKET_FRAMER -- requirements
Module: pixel_packet_framer

Interface
REQ-001 SHALL have parameter BYTES_PER_PIX, default 6: bytes per output pixel beat, legal range 2..8.
REQ-002 SHALL have parameter MAX_DLEN, default 64: maximum payload bytes per packet.
REQ-003 SHALL have parameter H_ACTIVE, default 640: active pixels per line.
REQ-004 SHALL have parameter V_ACTIVE, default 480: active lines per frame.
REQ-005 SHALL have port tx_pixel_clk, input, 1 bit: the only clock; all logic on its rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-007 SHALL have ports x and y, input, 10 bits each: current active-video pixel position from the timing generator.
REQ-008 SHALL have port data, input, MAX_DLEN*8 bits: payload; payload byte i is data[8i+7:8i].
REQ-009 SHALL have ports dlen (input, 16 bits, payload byte count) and dtype (input, 8 bits, packet type).
REQ-010 SHALL have ports data_valid (input, 1 bit) and data_ready (output, 1 bit): request handshake.
REQ-011 SHALL have port pixel_value, output, BYTES_PER_PIX*8 bits: registered pixel beat.
REQ-012 SHALL have ports busy (output, 1 bit, packet frame in progress) and len_err (output, 1 bit, one-cycle pulse).

Function
REQ-013 SHALL use the states IDLE, WAIT_SOF, STREAM, PAD and DONE.
REQ-014 SHALL drive data_ready=1 only in IDLE.
REQ-015 SHALL capture data, dlen and dtype into internal registers on data_valid&&data_ready, then go to WAIT_SOF and assert busy the next cycle.
REQ-016 SHALL, when captured dlen==0 or dlen>MAX_DLEN, drop the request instead: pulse len_err for one cycle, stay in IDLE, keep busy=0.
REQ-017 SHALL define the byte stream as: 0xEA, 0xFF, 0x00, dtype, dlen[7:0], dlen[15:8], payload bytes 0..dlen-1, 0xAA, 0xDD.
REQ-018 SHALL, in WAIT_SOF, output zero beats and move to STREAM in the cycle it samples x==0 and y==0.
REQ-019 SHALL, in STREAM, output one beat per clock, starting the cycle after the x==0,y==0 sample.
REQ-020 SHALL pack each beat from consecutive stream bytes, with the lowest-numbered byte in bits [7:0].
REQ-021 SHALL zero-fill the unused upper bytes of the final beat.
REQ-022 SHALL make the beat count ceil(L/BYTES_PER_PIX), where L is the total stream length in bytes.
REQ-023 SHALL go to PAD after the final beat and output zero beats there until it samples x==H_ACTIVE-1 and y==V_ACTIVE-1, then go to DONE.
REQ-024 SHALL, in DONE, deassert busy and return to IDLE the next cycle; data_ready is high in that IDLE cycle.
REQ-025 SHALL ignore data_valid while busy; captured registers SHALL NOT change mid-packet.
REQ-026 SHALL track the stream byte offset with a counter at least 16 bits wide, with no wrap for any legal dlen.
REQ-027 SHALL, if data_valid and len_err would coincide with a new request in the same IDLE cycle, apply only the length check to that request.

Reset
REQ-028 SHALL, while rst_n=0 at any time including mid-packet, force state IDLE and drive pixel_value=0, busy=0, len_err=0 and data_ready=0.
REQ-029 SHALL drive data_ready=1 on the first clock edge after rst_n deasserts.
REQ-030 SHALL discard any partially sent packet on reset; no resume.

Configuration
REQ-031 SHALL, with macro PIXEL_CRC_EN defined, append CRC-16/CCITT-FALSE after 0xDD: poly 0x1021, init 0xFFFF, no reflection, no final XOR.
REQ-032 SHALL compute that CRC over dtype, dlen[7:0], dlen[15:8] and all payload bytes, and append the low byte first, so L=dlen+10.
REQ-033 SHALL, without PIXEL_CRC_EN, end the stream at 0xDD with L=dlen+8 and contain no CRC logic.

Verification
REQ-034 SHALL cover: BYTES_PER_PIX=6, dlen=0x2B, dtype=0x01, CRC off, x=y=0 sampled -> beat0=0x002B0100FFEA, 9 beats total, beat8=0x000000DDAA followed by byte p42.
REQ-035 SHALL cover: dlen=0 or dlen=MAX_DLEN+1 with data_valid -> len_err high for exactly 1 cycle, busy stays 0, data_ready stays 1.
REQ-036 SHALL cover: data_valid pulsed with new data during STREAM -> output stream unchanged, request not captured.
REQ-037 SHALL cover: PIXEL_CRC_EN defined, dlen=1, dtype=0x01, payload 0x31, BYTES_PER_PIX=4 -> stream EA FF 00 01 01 00 31 AA DD crcL crcH, in 3 beats, with CRC matching the reference model.
REQ-038 SHALL cover: rst_n pulled low in the 3rd STREAM beat -> all outputs 0 asynchronously, and a new request after release is framed from beat0.
REQ-039 SHALL cover: end of PAD at x=639, y=479 -> busy falls the cycle after DONE, and back-to-back requests frame in consecutive video frames.

Source files
------------

// File: rtl/pixel_packet_framer.sv
// pixel_packet_framer: frames one captured request into a byte stream packed into pixel beats,
// starting at the first pixel of the next video frame. Optional trailing CRC-16: PIXEL_CRC_EN.
module pixel_packet_framer #(
  parameter int BYTES_PER_PIX = 6,
  parameter int MAX_DLEN      = 64,
  parameter int H_ACTIVE      = 640,
  parameter int V_ACTIVE      = 480
) (
  input  logic                       tx_pixel_clk,
  input  logic                       rst_n,
  input  logic [9:0]                 x,
  input  logic [9:0]                 y,
  input  logic [MAX_DLEN*8-1:0]      data,
  input  logic [15:0]                dlen,
  input  logic [7:0]                 dtype,
  input  logic                       data_valid,
  output logic                       data_ready,
  output logic [BYTES_PER_PIX*8-1:0] pixel_value,
  output logic                       busy,
  output logic                       len_err
);

`ifdef PIXEL_CRC_EN
  localparam int TRAILER = 10;
`else
  localparam int TRAILER = 8;
`endif
  localparam int PW = (MAX_DLEN > 1) ? $clog2(MAX_DLEN) : 1;

  typedef enum logic [2:0] {IDLE, WAIT_SOF, STREAM, PAD, DONE} state_t;
  state_t state;

  logic [7:0]  dtype_p0;
  logic [15:0] dlen_p0;
  logic [7:0]  pay_p0 [MAX_DLEN];
  logic [15:0] off_p0;

  logic [BYTES_PER_PIX*8-1:0] beat;
  logic [16:0] stream_len;
  logic [16:0] pay_end;
  logic [15:0] next_off;
  logic        sof, eof, len_bad, cap, emit, last;

`ifdef PIXEL_CRC_EN
  logic [15:0] crc_p0;
  logic [15:0] crc_nxt;

  function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] d);
    logic [15:0] c;
    c = crc ^ {d, 8'h00};
    for (int i = 0; i < 8; i++) c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
    return c;
  endfunction
`endif

  assign sof        = (x == 10'd0) && (y == 10'd0);
  assign eof        = (x == 10'(H_ACTIVE - 1)) && (y == 10'(V_ACTIVE - 1));
  assign len_bad    = (dlen == 16'd0) || (dlen > 16'(MAX_DLEN));
  assign cap        = (state == IDLE) && data_valid && data_ready && !len_bad;
  assign emit       = ((state == WAIT_SOF) && sof) || (state == STREAM);
  assign stream_len = {1'b0, dlen_p0} + 17'(TRAILER);
  assign pay_end    = {1'b0, dlen_p0} + 17'd6;
  assign next_off   = off_p0 + 16'(BYTES_PER_PIX);
  assign last       = {1'b0, next_off} >= stream_len;

  // Beat assembly: map each byte lane to its stream position; CRC bytes follow every covered byte.
  always_comb begin : beat_build
    logic [16:0] pos;
    logic [7:0]  sb;
    beat = '0;
    pos  = '0;
    sb   = '0;
`ifdef PIXEL_CRC_EN
    crc_nxt = crc_p0;
`endif
    for (int b = 0; b < BYTES_PER_PIX; b++) begin
      pos = {1'b0, off_p0} + 17'(b);
      sb  = 8'h00;
      if      (pos == 17'd0)            sb = 8'hEA;
      else if (pos == 17'd1)            sb = 8'hFF;
      else if (pos == 17'd2)            sb = 8'h00;
      else if (pos == 17'd3)            sb = dtype_p0;
      else if (pos == 17'd4)            sb = dlen_p0[7:0];
      else if (pos == 17'd5)            sb = dlen_p0[15:8];
      else if (pos < pay_end)           sb = pay_p0[PW'(pos - 17'd6)];
      else if (pos == pay_end)          sb = 8'hAA;
      else if (pos == pay_end + 17'd1)  sb = 8'hDD;
`ifdef PIXEL_CRC_EN
      else if (pos == pay_end + 17'd2)  sb = crc_nxt[7:0];
      else if (pos == pay_end + 17'd3)  sb = crc_nxt[15:8];
      if (pos >= 17'd3 && pos < pay_end) crc_nxt = crc16_byte(crc_nxt, sb);
`endif
      beat[8*b +: 8] = sb;
    end
  end

  // Capture stage: request fields frozen for the whole packet.
  always_ff @(posedge tx_pixel_clk) begin
    if (cap) begin
      dtype_p0 <= dtype;
      dlen_p0  <= dlen;
      for (int i = 0; i < MAX_DLEN; i++) pay_p0[i] <= data[8*i +: 8];
    end
`ifdef PIXEL_CRC_EN
    if (cap)       crc_p0 <= 16'hFFFF;
    else if (emit) crc_p0 <= crc_nxt;
`endif
  end

  always_ff @(posedge tx_pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      data_ready  <= 1'b0;
      busy        <= 1'b0;
      len_err     <= 1'b0;
      pixel_value <= '0;
      off_p0      <= '0;
    end else begin
      len_err <= 1'b0;
      case (state)
        IDLE: begin
          data_ready  <= 1'b1;
          pixel_value <= '0;
          if (data_valid && data_ready) begin
            if (len_bad) begin
              len_err <= 1'b1;
            end else begin
              state      <= WAIT_SOF;
              busy       <= 1'b1;
              data_ready <= 1'b0;
              off_p0     <= '0;
            end
          end
        end
        WAIT_SOF: begin
          pixel_value <= '0;
          if (sof) begin
            pixel_value <= beat;
            off_p0      <= next_off;
            state       <= last ? PAD : STREAM;
          end
        end
        STREAM: begin
          pixel_value <= beat;
          off_p0      <= next_off;
          if (last) state <= PAD;
        end
        PAD: begin
          pixel_value <= '0;
          if (eof) state <= DONE;
        end
        DONE: begin
          busy       <= 1'b0;
          data_ready <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
